// File: rtl/fpga_top.sv
// FPGA top: registered GPIO loopback, a sequencer that sends "Hello\n" over an 8N1 UART
// and then latches an exit code, plus an independent UART receiver driving output_pins2.
module fpga_top #(
  parameter int BAUD_DIV    = 16,
  parameter int START_DELAY = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] input_pins,
  output logic [7:0] output_pins,
  input  logic [7:0] input_pins2,
  output logic [7:0] output_pins2,
  output logic [7:0] output_pins3,
  output logic       output_pins3_update,
  output logic [7:0] output_pins4,
  output logic       output_pins4_update,
  input  logic       rxd,
  output logic       txd,
  input  logic       cts,
  output logic       rts,
  output logic       n_tx_en
);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_SEND   = 3'd1;
  localparam logic [2:0] S_TXWAIT = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] BAUD_PRE  = 16'(BAUD_DIV - 2);
  localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2 - 1);
  localparam logic [31:0] WAIT_LAST = (START_DELAY > 0) ? 32'(START_DELAY - 1) : 32'd0;

  function automatic logic [7:0] msg_char(input logic [2:0] i);
    case (i)
      3'd0:    msg_char = 8'h48;
      3'd1:    msg_char = 8'h65;
      3'd2:    msg_char = 8'h6C;
      3'd3:    msg_char = 8'h6C;
      3'd4:    msg_char = 8'h6F;
      default: msg_char = 8'h0A;
    endcase
  endfunction

  logic [2:0]  state;
  logic [2:0]  idx;
  logic [31:0] wait_cnt;

  logic        tx_busy;
  logic [3:0]  tx_bit;
  logic [15:0] tx_cnt;
  logic [7:0]  tx_shift;
  logic        tx_last;
  logic        tx_near_end;
  logic        tx_ready;
  logic        tx_start;

  logic        rx_sync1;
  logic        rx_sync2;
  logic        rx_prev;
  logic [1:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_load;

  // The sequencer leaves TXWAIT one cycle before the stop bit ends and the transmitter
  // accepts a new frame in its final stop cycle, so characters go out back to back.
  assign tx_last     = tx_busy && (tx_bit == 4'd9) && (tx_cnt == BAUD_LAST);
  assign tx_near_end = tx_busy && (tx_bit == 4'd9) && (tx_cnt == BAUD_PRE);
  assign tx_ready    = !tx_busy || tx_last;
  assign tx_start    = (state == S_SEND) && !cts && tx_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      output_pins <= 8'h00;
      rts         <= 1'b1;
    end else begin
      output_pins <= input_pins;
      rts         <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state               <= S_WAIT;
      idx                 <= 3'd0;
      wait_cnt            <= 32'd0;
      output_pins3        <= 8'h00;
      output_pins3_update <= 1'b0;
      output_pins4        <= 8'h00;
      output_pins4_update <= 1'b0;
    end else begin
      output_pins3_update <= 1'b0;
      output_pins4_update <= 1'b0;
      case (state)
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= S_SEND;
          else wait_cnt <= wait_cnt + 32'd1;
        end
        S_SEND: begin
          if (tx_start) begin
            output_pins3        <= msg_char(idx);
            output_pins3_update <= 1'b1;
            state               <= S_TXWAIT;
          end
        end
        S_TXWAIT: begin
          if (tx_near_end) begin
            if (idx == 3'd5) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 3'd1;
              state <= S_SEND;
            end
          end
        end
        S_DONE: begin
          output_pins4        <= input_pins2;
          output_pins4_update <= 1'b1;
          state               <= S_HALT;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_WAIT;
      endcase
    end
  end

  // Bit 0 is the start bit, 1..8 data, 9 stop; ones shifted in make the stop bit fall out.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tx_busy  <= 1'b0;
      tx_bit   <= 4'd0;
      tx_cnt   <= 16'd0;
      tx_shift <= 8'hFF;
      txd      <= 1'b1;
      n_tx_en  <= 1'b1;
    end else if (tx_start) begin
      tx_busy  <= 1'b1;
      tx_bit   <= 4'd0;
      tx_cnt   <= 16'd0;
      tx_shift <= msg_char(idx);
      txd      <= 1'b0;
      n_tx_en  <= 1'b0;
    end else if (tx_busy) begin
      if (tx_cnt == BAUD_LAST) begin
        tx_cnt <= 16'd0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          txd     <= 1'b1;
          n_tx_en <= 1'b1;
        end else begin
          tx_bit   <= tx_bit + 4'd1;
          txd      <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[7:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + 16'd1;
      end
    end
  end

  // A start edge is confirmed at mid start bit; the byte is committed a cycle after a good stop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_sync1     <= 1'b1;
      rx_sync2     <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= R_IDLE;
      rx_cnt       <= 16'd0;
      rx_bit       <= 3'd0;
      rx_shift     <= 8'h00;
      rx_load      <= 1'b0;
      output_pins2 <= 8'h00;
    end else begin
      rx_sync1 <= rxd;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
      rx_load  <= 1'b0;
      if (rx_load) output_pins2 <= rx_shift;
      case (rx_state)
        R_IDLE: begin
          if (rx_prev && !rx_sync2) begin
            rx_state <= R_START;
            rx_cnt   <= 16'd0;
          end
        end
        R_START: begin
          if (rx_cnt == BAUD_HALF) begin
            rx_cnt <= 16'd0;
            rx_bit <= 3'd0;
            rx_state <= rx_sync2 ? R_IDLE : R_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        R_DATA: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt   <= 16'd0;
            rx_shift <= {rx_sync2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= R_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: begin
          if (rx_cnt == BAUD_LAST) begin
            rx_cnt   <= 16'd0;
            rx_load  <= rx_sync2;
            rx_state <= R_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_top.sv
// Scoreboard bench for fpga_top: expected characters, exit codes and UART frames are queued
// when reset is released and consumed by monitors; received bytes follow a last-good-byte model.
module tb_fpga_top;

  localparam int BAUD = 16;
  localparam int FRAME = 10 * BAUD;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] input_pins;
  logic [7:0] output_pins;
  logic [7:0] input_pins2;
  logic [7:0] output_pins2;
  logic [7:0] output_pins3;
  logic       output_pins3_update;
  logic [7:0] output_pins4;
  logic       output_pins4_update;
  logic       rxd;
  logic       txd;
  logic       cts;
  logic       rts;
  logic       n_tx_en;

  fpga_top #(.BAUD_DIV(BAUD), .START_DELAY(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .input_pins(input_pins), .output_pins(output_pins),
    .input_pins2(input_pins2), .output_pins2(output_pins2),
    .output_pins3(output_pins3), .output_pins3_update(output_pins3_update),
    .output_pins4(output_pins4), .output_pins4_update(output_pins4_update),
    .rxd(rxd), .txd(txd), .cts(cts), .rts(rts), .n_tx_en(n_tx_en)
  );

  initial forever #5 clk = ~clk;

  logic [7:0] hello [6] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0A};

  int errors = 0;
  int checks = 0;
  logic [7:0] exp3 [$];
  logic [7:0] exp_tx [$];
  logic [7:0] exp4 [$];
  int cyc = 0;
  int last_cyc = 0;
  bit have_last = 0;
  int strobe_count = 0;
  int ntx_low = 0;
  int tx_frames = 0;
  int rst_count = 0;
  bit txd_low_seen = 0;
  logic [7:0] rx_model = 8'h00;
  logic [7:0] last_code = 8'h00;
  logic prev_upd3 = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic apply_reset();
    n_rst = 1'b0;
    exp3.delete();
    exp_tx.delete();
    exp4.delete();
    have_last = 0;
    ntx_low = 0;
    tx_frames = 0;
    rst_count++;
    rx_model = 8'h00;
  endtask

  task automatic release_reset(input logic [7:0] code);
    @(negedge clk);
    input_pins2 = code;
    last_code = code;
    for (int i = 0; i < 6; i++) begin
      exp3.push_back(hello[i]);
      exp_tx.push_back(hello[i]);
    end
    exp4.push_back(code);
    n_rst = 1'b1;
  endtask

  task automatic check_reset_outputs();
    check_output("rst_output_pins", output_pins, 0);
    check_output("rst_output_pins2", output_pins2, 0);
    check_output("rst_output_pins3", output_pins3, 0);
    check_output("rst_output_pins4", output_pins4, 0);
    check_output("rst_upd3", output_pins3_update, 0);
    check_output("rst_upd4", output_pins4_update, 0);
    check_output("rst_txd", txd, 1);
    check_output("rst_n_tx_en", n_tx_en, 1);
    check_output("rst_rts", rts, 1);
  endtask

  task automatic apply_stimulus(input int count);
    logic [7:0] v;
    for (int i = 0; i < count; i++) begin
      v = (i == 0) ? 8'h3C : 8'($urandom);
      input_pins = v;
      @(negedge clk);
      check_output("gpio_loopback", output_pins, v);
    end
  endtask

  task automatic send_rx(input logic [7:0] data, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (BAUD) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (BAUD) @(negedge clk);
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    if (stop_bit) rx_model = data;
    check_output(stop_bit ? "rx_byte" : "rx_framing_error", output_pins2, rx_model);
  endtask

  task automatic send_glitch();
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check_output("rx_glitch", output_pins2, rx_model);
  endtask

  task automatic wait_run_done(input int budget);
    int n = 0;
    while (exp4.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("run_complete", exp4.size(), 0);
    repeat (200) @(negedge clk);
    check_output("tx_frames", tx_frames, 6);
    check_output("n_tx_en_low_cycles", ntx_low, 6 * FRAME);
    check_output("chars_left", exp3.size(), 0);
    check_output("frames_left", exp_tx.size(), 0);
    check_output("exit_code_held", output_pins4, last_code);
  endtask

  initial forever @(posedge clk) cyc++;

  // Character / exit-code monitor with spacing and pulse-width checks.
  initial begin : strobe_monitor
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (txd === 1'b0) txd_low_seen = 1;
        if (n_tx_en === 1'b0) ntx_low++;
        if (output_pins3_update) begin
          strobe_count++;
          check_output("upd3_width", prev_upd3, 0);
          if (exp3.size() == 0) begin
            check_output("unexpected_char_strobe", 1, 0);
          end else begin
            e = exp3.pop_front();
            check_output("char", output_pins3, e);
          end
          if (have_last) check_output("char_spacing", cyc - last_cyc, FRAME);
          last_cyc = cyc;
          have_last = 1;
        end
        if (output_pins4_update) begin
          if (exp4.size() == 0) begin
            check_output("unexpected_exit_strobe", 1, 0);
          end else begin
            e = exp4.pop_front();
            check_output("exit_code", output_pins4, e);
            check_output("exit_spacing", cyc - last_cyc, FRAME);
          end
        end
      end
      prev_upd3 = output_pins3_update;
    end
  end

  // Decodes txd frames by sampling bit centres; frames cut short by reset are discarded.
  initial begin : tx_decoder
    logic [7:0] b;
    logic start_ok;
    logic en_ok;
    logic stop_b;
    logic [7:0] e;
    int my_rst;
    forever begin
      @(negedge clk);
      if (n_rst && txd === 1'b0) begin
        my_rst = rst_count;
        en_ok = (n_tx_en === 1'b0);
        repeat (BAUD / 2 - 1) @(negedge clk);
        start_ok = (txd === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = txd;
        end
        repeat (BAUD) @(negedge clk);
        stop_b = txd;
        if (my_rst == rst_count) begin
          tx_frames++;
          check_output("tx_n_tx_en_at_start", en_ok, 1);
          check_output("tx_start_bit", start_ok, 1);
          check_output("tx_stop_bit", stop_b, 1);
          if (exp_tx.size() == 0) begin
            check_output("unexpected_tx_frame", 1, 0);
          end else begin
            e = exp_tx.pop_front();
            check_output("tx_frame_data", b, e);
          end
        end
      end
    end
  end

  initial begin
    int base;
    int n;
    rxd = 1'b1;
    cts = 1'b0;
    input_pins = 8'h00;
    input_pins2 = 8'h00;
    apply_reset();
    input_pins = 8'($urandom);
    repeat (5) @(negedge clk);
    check_reset_outputs();

    // Normal run with concurrent reception and GPIO traffic.
    release_reset(8'h2A);
    repeat (2) @(negedge clk);
    check_output("rts_active", rts, 0);
    apply_stimulus(20);
    send_rx(8'hA5, 1'b1);
    send_rx(8'($urandom), 1'b0);
    send_glitch();
    send_rx(8'($urandom), 1'b1);
    send_rx(8'($urandom), 1'b1);
    wait_run_done(4000);

    // Flow control: nothing leaves while cts is high; mid-frame cts changes are ignored.
    apply_reset();
    cts = 1'b1;
    repeat (5) @(negedge clk);
    release_reset(8'($urandom));
    base = strobe_count;
    txd_low_seen = 0;
    repeat (1000) @(negedge clk);
    check_output("cts_hold_strobes", strobe_count - base, 0);
    check_output("cts_hold_txd_low", txd_low_seen, 0);
    cts = 1'b0;
    @(negedge clk);
    check_output("cts_release_strobe", output_pins3_update, 1);
    check_output("cts_release_char", output_pins3, 8'h48);
    repeat (50) @(negedge clk);
    cts = 1'b1;
    repeat (50) @(negedge clk);
    cts = 1'b0;
    wait_run_done(4000);

    // Reset during the third character aborts the frame and restarts the message.
    apply_reset();
    repeat (5) @(negedge clk);
    release_reset(8'($urandom));
    base = strobe_count;
    n = 0;
    while (strobe_count - base < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_output("third_char_reached", (strobe_count - base >= 3) ? 1 : 0, 1);
    repeat (40) @(negedge clk);
    #3;
    apply_reset();
    #1;
    check_reset_outputs();
    repeat (200) @(negedge clk);
    release_reset(8'($urandom));
    wait_run_done(4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpga_top.md
FPGA_TOP -- requirements
Module: FpgaTop

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 16, meaning clk cycles per UART bit (legal range 4..65535).
REQ-002 SHALL have parameter START_DELAY, default 8, meaning clk cycles from reset release to the first message character.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port input_pins  input  8  GPIO1 inputs.
REQ-006 SHALL have port output_pins  output  8  GPIO1 outputs.
REQ-007 SHALL have port input_pins2  input  8  GPIO2 inputs; supplies the exit code.
REQ-008 SHALL have port output_pins2  output  8  last UART byte received.
REQ-009 SHALL have port output_pins3  output  8  console character.
REQ-010 SHALL have port output_pins3_update  output  1  one-cycle strobe marking a new output_pins3 value.
REQ-011 SHALL have port output_pins4  output  8  exit code.
REQ-012 SHALL have port output_pins4_update  output  1  one-cycle strobe marking a new exit code.
REQ-013 SHALL have port rxd  input  1  UART receive data, idle high.
REQ-014 SHALL have port txd  output  1  UART transmit data, idle high.
REQ-015 SHALL have port cts  input  1  clear-to-send, active-low.
REQ-016 SHALL have port rts  output  1  request-to-send, active-low.
REQ-017 SHALL have port n_tx_en  output  1  transmit driver enable, active-low.

Function
REQ-018 SHALL register output_pins <= input_pins every cycle, giving 1-cycle latency.
REQ-019 SHALL run a sequencer with states WAIT -> SEND -> TXWAIT -> (SEND | DONE) -> HALT.
REQ-020 SHALL use the fixed message "Hello\n" (0x48 0x65 0x6C 0x6C 0x6F 0x0A), indexed 0..5.
REQ-021 WAIT SHALL count START_DELAY cycles, then go to SEND.
REQ-022 SEND SHALL wait while cts=1 or the transmitter is busy; otherwise, in one cycle, it SHALL set output_pins3 to the current character, pulse output_pins3_update for exactly 1 cycle, start the transmitter, and go to TXWAIT.
REQ-023 TXWAIT SHALL wait for the end of the stop bit, then increment the index and go to SEND, or go to DONE after index 5.
REQ-024 DONE SHALL, in one cycle, set output_pins4 to input_pins2 sampled that cycle, pulse output_pins4_update for 1 cycle, and go to HALT.
REQ-025 HALT SHALL be terminal until reset, with no further strobes.
REQ-026 The transmitter SHALL send 8N1, LSB first: start 0, 8 data bits, stop 1, each held BAUD_DIV cycles, so one frame is 10*BAUD_DIV cycles.
REQ-027 txd SHALL be 1 when idle.
REQ-028 n_tx_en SHALL be 0 from the start-bit cycle through the last stop-bit cycle, and 1 otherwise.
REQ-029 A cts change mid-frame SHALL NOT affect the current frame; cts is checked only before a frame starts.
REQ-030 The receiver SHALL synchronise rxd through 2 flip-flops.
REQ-031 The receiver SHALL detect a falling edge in idle and recheck at mid start bit (BAUD_DIV/2); if rxd is high there, it SHALL return to idle (glitch).
REQ-032 The receiver SHALL sample 8 data bits LSB first at bit centres, then the stop bit.
REQ-033 If the stop bit is 1, output_pins2 SHALL take the byte on the cycle after the stop-bit sample; if it is 0 (framing error), the byte SHALL be discarded and output_pins2 left unchanged.
REQ-034 rts SHALL be 0 whenever out of reset (always ready).
REQ-035 Receiver and transmitter SHALL operate independently and concurrently; simultaneous RX and TX SHALL NOT interfere.

Reset
REQ-036 While n_rst=0, all outputs SHALL be: output_pins=0, output_pins2=0, output_pins3=0, output_pins4=0, both update strobes 0, txd=1, n_tx_en=1, rts=1.
REQ-037 While n_rst=0, the sequencer SHALL be in WAIT with index 0 and the receiver idle.
REQ-038 Reset asserted mid-operation (including mid-frame) SHALL abort immediately; after release the message SHALL restart from 'H'.

Verification
REQ-039 Scenario: BAUD_DIV=16, cts=0, reset 5 cycles -> 6 output_pins3_update pulses carrying 0x48,0x65,0x6C,0x6C,0x6F,0x0A, spaced 160 cycles apart.
REQ-040 Scenario: input_pins2=0x2A, run to end -> single output_pins4_update pulse 160 cycles after the last character strobe, with output_pins4=0x2A.
REQ-041 Scenario: decode txd -> frames match the characters; n_tx_en is low exactly 160 cycles per frame.
REQ-042 Scenario: hold cts=1 for 1000 cycles after reset -> no strobe and txd=1; drop cts -> 'H' strobe on the next eligible cycle.
REQ-043 Scenario: drive 0xA5 on rxd at BAUD_DIV=16 -> output_pins2=0xA5; then a frame with stop=0 -> output_pins2 stays 0xA5; a 3-cycle low glitch -> no change.
REQ-044 Scenario: toggle input_pins=0x3C -> output_pins=0x3C one cycle later; assert n_rst during the 3rd character -> outputs return to reset values and the sequence restarts at 'H'.
